// File: rtl/cannon_bullets_pkg.sv
// ---------------------------------------------------------------------------
// cannon_bullets_pkg : slot record type and lane geometry for cannon_bullets
// Revision: 1.0
// ---------------------------------------------------------------------------
`include "game_constants.sv"
`default_nettype none

package cannon_bullets_pkg;

   localparam int POS_W = 11;
   localparam int ADD_W = 12;

   typedef struct packed {
      logic             active;
      logic [POS_W-1:0] pos;
   } slot_t;

   localparam slot_t SLOT_IDLE = '{active: 1'b0, pos: POS_W'(`BULLET_STARTING_POS_X)};

   // A bullet whose leading edge would cross this after its next step is retired.
   localparam logic [ADD_W-1:0] RIGHT_LIMIT = ADD_W'(`WIDTH - `FRAME_WIDTH);

endpackage

`default_nettype wire

// File: rtl/cannon_bullets_bullet_slot.sv
// ---------------------------------------------------------------------------
// bullet_slot : one bullet slot (position, active flag, retirement)
// Revision: 1.0
// ---------------------------------------------------------------------------
`include "game_constants.sv"
`default_nettype none

module bullet_slot
   import cannon_bullets_pkg::*;
#(
   parameter int BULLET_SPEED = 4
)(
   input  logic             logclk,
   input  logic             rst,
   input  logic             clear,
   input  logic             freeze,
   input  logic             hit,
   input  logic             launch,
   output logic             active,
   output logic [POS_W-1:0] pos
);

   slot_t            slot_q, slot_d;
   logic [ADD_W-1:0] next_pos;
   logic [ADD_W-1:0] reach;

   always_comb begin
      slot_d   = slot_q;
      next_pos = {1'b0, slot_q.pos} + ADD_W'(BULLET_SPEED);
      reach    = next_pos + ADD_W'(`BULLET_WIDTH);
      if (clear) begin
         slot_d = SLOT_IDLE;
      end else if (slot_q.active) begin
         // Hits retire even while frozen; the edge test only runs while moving.
         if (hit || (!freeze && (reach >= RIGHT_LIMIT))) begin
            slot_d = SLOT_IDLE;
         end else if (!freeze) begin
            slot_d.pos = next_pos[POS_W-1:0];
         end
      end else if (launch) begin
         slot_d.active = 1'b1;
         slot_d.pos    = POS_W'(`BULLET_STARTING_POS_X + BULLET_SPEED);
      end
   end

   always_ff @(posedge logclk or posedge rst) begin
      if (rst) begin
         slot_q <= SLOT_IDLE;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign active = slot_q.active;
   assign pos    = slot_q.pos;

endmodule

`default_nettype wire

// File: rtl/game_constants.sv
// ---------------------------------------------------------------------------
// game_constants : playfield and bullet geometry shared by all game blocks
// Revision: 1.0
// ---------------------------------------------------------------------------
`ifndef GAME_CONSTANTS_SV
`define GAME_CONSTANTS_SV
`default_nettype none

`define WIDTH                 640
`define FRAME_WIDTH           8
`define BULLET_WIDTH          4
`define BULLET_STARTING_POS_X 40
`define BULLETS_PER_CANNON    4

`default_nettype wire
`endif

// File: rtl/cannon_bullets.sv
// ---------------------------------------------------------------------------
// cannon_bullets : bullet lane with launch arbitration, cooldown and ammo.
// CANNON_BULLETS_AMMO_LIMIT_EN selects finite ammo. Revision: 1.0
// ---------------------------------------------------------------------------
`include "game_constants.sv"
`default_nettype none

module cannon_bullets
   import cannon_bullets_pkg::*;
#(
   parameter int NUM_BULLETS  = `BULLETS_PER_CANNON,
   parameter int BULLET_SPEED = 4,
   parameter int COOLDOWN     = 32,
   parameter int AMMO_INIT    = 20
)(
   input  logic                         logclk,
   input  logic                         rst,
   input  logic                         btn_c,
   input  logic                         fire_btn,
   input  logic                         global_gameover,
   input  logic [NUM_BULLETS-1:0]       hit_mask,
   output logic [POS_W*NUM_BULLETS-1:0] line_bullet_pos_x,
   output logic [NUM_BULLETS-1:0]       bullets_active,
   output logic                         fire_ack,
   output logic [7:0]                   ammo_left
);

   localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

   logic                   fire_prev_q, fire_prev_d;
   logic                   fire_ack_q, fire_ack_d;
   logic [CD_W-1:0]        cooldown_q, cooldown_d;
   logic [NUM_BULLETS-1:0] free_slots;
   logic [NUM_BULLETS-1:0] launch_sel;
   logic                   fire_edge;
   logic                   ammo_ok;
   logic                   launch;

   assign free_slots = ~bullets_active;
   // Isolates the lowest set bit, i.e. the lowest-index free slot.
   assign launch_sel = free_slots & (~free_slots + NUM_BULLETS'(1));
   assign fire_edge  = fire_btn & ~fire_prev_q;
   assign launch     = fire_edge && !btn_c && !global_gameover &&
                       (cooldown_q == '0) && (|free_slots) && ammo_ok;

   always_comb begin
      fire_prev_d = btn_c ? 1'b1 : fire_btn;
      fire_ack_d  = launch;
      cooldown_d  = cooldown_q;
      if (btn_c) begin
         cooldown_d = '0;
      end else if (launch) begin
         cooldown_d = CD_W'(COOLDOWN - 1);
      end else if (!global_gameover && (cooldown_q != '0)) begin
         cooldown_d = cooldown_q - CD_W'(1);
      end
   end

   always_ff @(posedge logclk or posedge rst) begin
      if (rst) begin
         fire_prev_q <= 1'b1;
         fire_ack_q  <= 1'b0;
         cooldown_q  <= '0;
      end else begin
         fire_prev_q <= fire_prev_d;
         fire_ack_q  <= fire_ack_d;
         cooldown_q  <= cooldown_d;
      end
   end

   assign fire_ack = fire_ack_q;

`ifdef CANNON_BULLETS_AMMO_LIMIT_EN
   logic [7:0] ammo_q, ammo_d;

   assign ammo_ok = (ammo_q != 8'd0);

   always_comb begin
      ammo_d = ammo_q;
      if (btn_c) begin
         ammo_d = 8'(AMMO_INIT);
      end else if (launch) begin
         ammo_d = ammo_q - 8'd1;
      end
   end

   always_ff @(posedge logclk or posedge rst) begin
      if (rst) begin
         ammo_q <= 8'(AMMO_INIT);
      end else begin
         ammo_q <= ammo_d;
      end
   end

   assign ammo_left = ammo_q;
`else
   assign ammo_ok   = 1'b1;
   // Unlimited ammo reads as all ones regardless of AMMO_INIT.
   assign ammo_left = 8'hFF | 8'(AMMO_INIT);
`endif

   for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
      bullet_slot #(
         .BULLET_SPEED (BULLET_SPEED)
      ) u_slot (
         .logclk (logclk),
         .rst    (rst),
         .clear  (btn_c),
         .freeze (global_gameover),
         .hit    (hit_mask[i]),
         .launch (launch & launch_sel[i]),
         .active (bullets_active[i]),
         .pos    (line_bullet_pos_x[POS_W*i +: POS_W])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_cannon_bullets.sv
// ---------------------------------------------------------------------------
// tb_cannon_bullets : directed scoreboard bench for cannon_bullets
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cannon_bullets;

   localparam int S   = 40;
   localparam int SPD = 4;
   localparam int BW  = 4;
   localparam int LIM = 632;
`ifdef CANNON_BULLETS_AMMO_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic        logclk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_c = 1'b0;
   logic        fire_btn = 1'b0;
   logic        global_gameover = 1'b0;
   logic [3:0]  hit_mask = 4'b0;
   logic [43:0] line_bullet_pos_x;
   logic [3:0]  bullets_active;
   logic        fire_ack;
   logic [7:0]  ammo_left;

   logic        fire2 = 1'b0;
   logic [43:0] pos2;
   logic [3:0]  act2;
   logic        ack2;
   logic [7:0]  ammo2;

   typedef logic [56:0] snap_t;
   typedef struct packed { snap_t exp; snap_t got; } sb_t;
   sb_t        sb[$];
   logic [8:0] ammo_exp_q[$];

   int   checks = 0;
   int   errors = 0;
   logic m_act[4];
   int   m_pos[4];
   logic m_ack;
   int   m_ammo;

   cannon_bullets #(.NUM_BULLETS(4), .BULLET_SPEED(4), .COOLDOWN(32), .AMMO_INIT(20)) dut (
      .logclk(logclk), .rst(rst), .btn_c(btn_c), .fire_btn(fire_btn),
      .global_gameover(global_gameover), .hit_mask(hit_mask),
      .line_bullet_pos_x(line_bullet_pos_x), .bullets_active(bullets_active),
      .fire_ack(fire_ack), .ammo_left(ammo_left));

   cannon_bullets #(.NUM_BULLETS(4), .BULLET_SPEED(4), .COOLDOWN(32), .AMMO_INIT(2)) dut2 (
      .logclk(logclk), .rst(rst), .btn_c(1'b0), .fire_btn(fire2),
      .global_gameover(1'b0), .hit_mask(4'b0),
      .line_bullet_pos_x(pos2), .bullets_active(act2),
      .fire_ack(ack2), .ammo_left(ammo2));

   always #5 logclk = ~logclk;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_act[i] = 1'b0;
         m_pos[i] = S;
      end
      m_ack  = 1'b0;
      m_ammo = LIMIT ? 20 : 255;
   endfunction

   function automatic snap_t model_snap();
      logic [3:0]  a;
      logic [43:0] p;
      for (int i = 0; i < 4; i++) begin
         a[i]          = m_act[i];
         p[11*i +: 11] = 11'(m_pos[i]);
      end
      return {a, p, m_ack, 8'(m_ammo)};
   endfunction

   // Drives one cycle, advances the model with the launch the test expects,
   // and queues expected/observed snapshots for the calling test to compare.
   task automatic drive_cycle(input logic f, input logic go, input logic [3:0] hit,
                              input logic c, input int launch);
      sb_t e;
      fire_btn = f; global_gameover = go; hit_mask = hit; btn_c = c;
      if (c) begin
         model_reset();
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (m_act[i]) begin
               if (hit[i] || (!go && (m_pos[i] + BW + SPD >= LIM))) begin
                  m_act[i] = 1'b0;
                  m_pos[i] = S;
               end else if (!go) begin
                  m_pos[i] = m_pos[i] + SPD;
               end
            end else if (i == launch) begin
               m_act[i] = 1'b1;
               m_pos[i] = S + SPD;
            end
         end
         m_ack = (launch >= 0);
         if (LIMIT && launch >= 0) m_ammo = m_ammo - 1;
      end
      e.exp = model_snap();
      @(posedge logclk); #1;
      e.got = {bullets_active, line_bullet_pos_x, fire_ack, ammo_left};
      sb.push_back(e);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) drive_cycle(1'b0, 1'b0, 4'b0, 1'b0, -1);
   endtask

   task automatic do_reset();
      fire_btn = 0; fire2 = 0; global_gameover = 0; hit_mask = 0; btn_c = 0;
      rst = 1'b1;
      @(posedge logclk); #1;
      rst = 1'b0;
      @(posedge logclk); #1;
      model_reset();
      sb.delete();
   endtask

   task automatic launch_four();
      for (int k = 0; k < 4; k++) begin
         drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, k);
         idle_cycles(31);
      end
   endtask

   task automatic test_reset();
      sb_t e;
      model_reset();
      @(posedge logclk); #1;
      e.exp = model_snap();
      e.got = {bullets_active, line_bullet_pos_x, fire_ack, ammo_left};
      sb.push_back(e);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (e.got !== e.exp) begin
            errors++;
            $display("FAIL reset: got %h want %h", e.got, e.exp);
         end
      end
   endtask

   task automatic test_single_fire();
      sb_t e;
      int  k = 0;
      do_reset();
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, 0);
      idle_cycles(4);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (e.got !== e.exp) begin
            errors++;
            $display("FAIL single_fire step %0d: got %h want %h", k, e.got, e.exp);
         end
         k++;
      end
   endtask

   task automatic test_cooldown();
      sb_t e;
      int  k = 0;
      do_reset();
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, 0);
      idle_cycles(9);
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, -1);
      idle_cycles(19);
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, -1);
      idle_cycles(1);
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, 1);
      idle_cycles(2);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (e.got !== e.exp) begin
            errors++;
            $display("FAIL cooldown step %0d: got %h want %h", k, e.got, e.exp);
         end
         k++;
      end
   endtask

   task automatic test_pool_full();
      sb_t e;
      int  k = 0;
      do_reset();
      launch_four();
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, -1);
      idle_cycles(20);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (e.got !== e.exp) begin
            errors++;
            $display("FAIL pool_full step %0d: got %h want %h", k, e.got, e.exp);
         end
         k++;
      end
   endtask

   task automatic test_hit_vs_fire();
      sb_t e;
      int  k = 0;
      do_reset();
      launch_four();
      idle_cycles(2);
      drive_cycle(1'b1, 1'b0, 4'b0001, 1'b0, -1);
      idle_cycles(1);
      drive_cycle(1'b1, 1'b0, 4'b0001, 1'b0, 0);
      idle_cycles(2);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (e.got !== e.exp) begin
            errors++;
            $display("FAIL hit_vs_fire step %0d: got %h want %h", k, e.got, e.exp);
         end
         k++;
      end
   endtask

   task automatic test_gameover();
      sb_t e;
      int  k = 0;
      do_reset();
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, 0);
      idle_cycles(40);
      drive_cycle(1'b0, 1'b1, 4'b0, 1'b0, -1);
      drive_cycle(1'b1, 1'b1, 4'b0, 1'b0, -1);
      drive_cycle(1'b0, 1'b1, 4'b0, 1'b0, -1);
      drive_cycle(1'b0, 1'b1, 4'b0001, 1'b0, -1);
      drive_cycle(1'b0, 1'b1, 4'b0, 1'b0, -1);
      idle_cycles(1);
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, 0);
      repeat (5) drive_cycle(1'b0, 1'b1, 4'b0, 1'b0, -1);
      idle_cycles(26);
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, -1);
      idle_cycles(4);
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, 1);
      idle_cycles(2);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (e.got !== e.exp) begin
            errors++;
            $display("FAIL gameover step %0d: got %h want %h", k, e.got, e.exp);
         end
         k++;
      end
   endtask

   task automatic test_restart();
      sb_t e;
      int  k = 0;
      do_reset();
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, 0);
      idle_cycles(3);
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b1, -1);
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, -1);
      idle_cycles(1);
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, 0);
      idle_cycles(1);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (e.got !== e.exp) begin
            errors++;
            $display("FAIL restart step %0d: got %h want %h", k, e.got, e.exp);
         end
         k++;
      end
   endtask

   task automatic test_async_reset();
      sb_t e;
      int  k = 0;
      do_reset();
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, 0);
      idle_cycles(2);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      e.exp = model_snap();
      e.got = {bullets_active, line_bullet_pos_x, fire_ack, ammo_left};
      sb.push_back(e);
      @(posedge logclk); #1;
      rst = 1'b0;
      @(posedge logclk); #1;
      drive_cycle(1'b1, 1'b0, 4'b0, 1'b0, 0);
      idle_cycles(1);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (e.got !== e.exp) begin
            errors++;
            $display("FAIL async_reset step %0d: got %h want %h", k, e.got, e.exp);
         end
         k++;
      end
   endtask

   task automatic test_ammo();
      logic [8:0] exp_v;
      logic [8:0] got_v[$];
      do_reset();
      for (int k = 0; k < 3; k++) begin
         if (LIMIT) ammo_exp_q.push_back({(k < 2), 8'((k < 1) ? 1 : 0)});
         else       ammo_exp_q.push_back({1'b1, 8'hFF});
         fire2 = 1'b1;
         @(posedge logclk); #1;
         got_v.push_back({ack2, ammo2});
         fire2 = 1'b0;
         repeat (33) begin
            @(posedge logclk); #1;
         end
      end
      for (int k = 0; k < 3; k++) begin
         exp_v = ammo_exp_q.pop_front();
         checks++;
         if (got_v[k] !== exp_v) begin
            errors++;
            $display("FAIL ammo edge %0d: got ack/ammo %h want %h", k, got_v[k], exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_fire();
      test_cooldown();
      test_pool_full();
      test_hit_vs_fire();
      test_gameover();
      test_restart();
      test_async_reset();
      test_ammo();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
